// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the Smith-Waterman array controller and the
// blocks that sit around the PE chain.
//   NUM_PE_DEF : default number of PEs in the chain (short-read length per job)
//   BASE_W     : nucleotide code width
//   SCORE_W    : V/E/F score width, compared as unsigned
//   REF_LEN_W  : width of the reference-length field and reference counter
package sw_pkg;

  localparam int NUM_PE_DEF = 8;
  localparam int BASE_W     = 2;
  localparam int SCORE_W    = 10;
  localparam int REF_LEN_W  = 16;

  typedef enum logic [BASE_W-1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // States in which a job is in flight and the tail PE may report scores.
  function automatic logic is_busy_state(input state_e s);
    return s inside {LOAD, STREAM, DRAIN};
  endfunction

endpackage

// File: rtl/sw_array_ctrl_if.sv
// sw_array_ctrl_if: job control, read/reference streams and PE-chain taps of
// the array controller.
//   job      : start, ref_len (host -> ctrl); busy, done, err, max_score back
//   read     : rd_valid/rd_base in, rd_ready out (last base of the read first)
//   reference: ref_valid/ref_base in, ref_ready out (in order)
//   PE0 feed : pe_S, pe_store_S, pe_T, pe_init, pe_V, pe_F (ctrl -> chain)
//   tail     : tail_V, tail_init (last PE -> ctrl)
// slave is the controller's view, master the host/chain side.
interface sw_array_ctrl_if;
  import sw_pkg::*;

  logic                 start;
  logic [REF_LEN_W-1:0] ref_len;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [SCORE_W-1:0]   max_score;

  logic                 rd_valid;
  logic [BASE_W-1:0]    rd_base;
  logic                 rd_ready;

  logic                 ref_valid;
  logic [BASE_W-1:0]    ref_base;
  logic                 ref_ready;

  logic [BASE_W-1:0]    pe_S;
  logic                 pe_store_S;
  logic [BASE_W-1:0]    pe_T;
  logic                 pe_init;
  logic [SCORE_W-1:0]   pe_V;
  logic [SCORE_W-1:0]   pe_F;

  logic [SCORE_W-1:0]   tail_V;
  logic                 tail_init;

  modport slave (
    input  start, ref_len, rd_valid, rd_base, ref_valid, ref_base,
           tail_V, tail_init,
    output busy, done, err, max_score, rd_ready, ref_ready,
           pe_S, pe_store_S, pe_T, pe_init, pe_V, pe_F
  );

  modport master (
    output start, ref_len, rd_valid, rd_base, ref_valid, ref_base,
           tail_V, tail_init,
    input  busy, done, err, max_score, rd_ready, ref_ready,
           pe_S, pe_store_S, pe_T, pe_init, pe_V, pe_F
  );

endinterface

// File: rtl/sw_max_tracker.sv
// sw_max_tracker: registered running maximum with synchronous clear.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : zero the maximum (has priority over a new value)
//   en       : tracking window open
//   valid    : value is a real score this cycle
//   value    : candidate score (unsigned)
//   max_o    : largest accepted value since the last clear; ties keep the old one
module sw_max_tracker #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         valid,
  input  logic [W-1:0] value,
  output logic [W-1:0] max_o
);

  logic [W-1:0] max_q, max_d;

  // NOTE: every variable assigned in an always_comb gets a default on the
  // first line so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    max_d = max_q;
    if (clr) begin
      max_d = '0;
    end else if (en && valid && (value > max_q)) begin
      max_d = value;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) max_q <= '0;
    else      max_q <= max_d;
  end

  assign max_o = max_q;

endmodule

// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl: sequencer for a linear chain of Smith-Waterman PEs, one
// alignment per job. Shifts NUM_PE read bases into the chain, streams the
// reference with a zero column boundary, tracks the best V reported by the
// last PE, drains the pipeline and reports the score.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : sw_array_ctrl_if.slave (job control, read/ref streams, PE taps)
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF
) (
  input logic              clk,
  input logic              rst,
  sw_array_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(NUM_PE + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(NUM_PE - 1);
  // Last tail column leaves the chain NUM_PE+1 cycles after the final pe_init.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(NUM_PE);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [REF_LEN_W-1:0] ref_len_q, ref_len_d;
  logic [REF_LEN_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [REF_LEN_W-1:0] ref_cnt_inc;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rd_ready_q, rd_ready_d;
  logic                 ref_ready_q, ref_ready_d;
  logic [BASE_W-1:0]    pe_S_q, pe_S_d;
  logic                 pe_store_S_q, pe_store_S_d;
  logic [BASE_W-1:0]    pe_T_q, pe_T_d;
  logic                 pe_init_q, pe_init_d;

  logic start_acc;
  logic rd_take;
  logic ref_take;

  assign start_acc   = (state_q == IDLE) && bus.start;
  assign rd_take     = rd_ready_q && bus.rd_valid;
  assign ref_take    = ref_ready_q && bus.ref_valid;
  assign ref_cnt_inc = ref_cnt_q + REF_LEN_W'(1);

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    ref_len_d    = ref_len_q;
    ref_cnt_d    = ref_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    rd_ready_d   = rd_ready_q;
    ref_ready_d  = ref_ready_q;
    pe_S_d       = pe_S_q;
    pe_store_S_d = 1'b0;
    pe_T_d       = pe_T_q;
    pe_init_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          ref_len_d   = bus.ref_len;
          ref_cnt_d   = '0;
          load_cnt_d  = '0;
          drain_cnt_d = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          if (bus.ref_len == '0) begin
            // Empty reference: one busy cycle, then DONE via a pre-expired drain.
            drain_cnt_d = DRAIN_LAST;
            state_d     = DRAIN;
          end else begin
            rd_ready_d = 1'b1;
            state_d    = LOAD;
          end
        end
      end

      LOAD: begin
        if (rd_take) begin
          pe_S_d       = bus.rd_base;
          pe_store_S_d = 1'b1;
          load_cnt_d   = load_cnt_q + CNT_W'(1);
          if (load_cnt_q == LOAD_LAST) begin
            // Drop ready with the last base so no extra base is consumed.
            rd_ready_d  = 1'b0;
            ref_ready_d = 1'b1;
            state_d     = STREAM;
          end
        end
      end

      STREAM: begin
        if (ref_take) begin
          pe_T_d    = bus.ref_base;
          pe_init_d = 1'b1;
          ref_cnt_d = ref_cnt_inc;
          if (ref_cnt_inc == ref_len_q) begin
            ref_ready_d = 1'b0;
            state_d     = DRAIN;
          end
        end else begin
          // The chain cannot hold a column half-computed: a gap aborts the job.
          err_d       = 1'b1;
          ref_ready_d = 1'b0;
          state_d     = DRAIN;
        end
      end

      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      ref_len_q    <= '0;
      ref_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_ready_q   <= 1'b0;
      ref_ready_q  <= 1'b0;
      pe_S_q       <= '0;
      pe_store_S_q <= 1'b0;
      pe_T_q       <= '0;
      pe_init_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      ref_len_q    <= ref_len_d;
      ref_cnt_q    <= ref_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_ready_q   <= rd_ready_d;
      ref_ready_q  <= ref_ready_d;
      pe_S_q       <= pe_S_d;
      pe_store_S_q <= pe_store_S_d;
      pe_T_q       <= pe_T_d;
      pe_init_q    <= pe_init_d;
    end
  end

  logic [SCORE_W-1:0] max_score;

  sw_max_tracker #(.W(SCORE_W)) u_max (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (is_busy_state(state_q)),
    .valid (bus.tail_init),
    .value (bus.tail_V),
    .max_o (max_score)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.max_score  = max_score;
  assign bus.rd_ready   = rd_ready_q;
  assign bus.ref_ready  = ref_ready_q;
  assign bus.pe_S       = pe_S_q;
  assign bus.pe_store_S = pe_store_S_q;
  assign bus.pe_T       = pe_T_q;
  assign bus.pe_init    = pe_init_q;
  // Column boundary of PE0: H and F above the first row are zero.
  assign bus.pe_V       = '0;
  assign bus.pe_F       = '0;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// tb_sw_array_ctrl: directed job vectors for sw_array_ctrl. A small model of
// the PE chain delays pe_init by NUM_PE cycles to form tail_init and reports a
// per-column running maximum from a Smith-Waterman reference model.
module tb_sw_array_ctrl;
  import sw_pkg::*;

  localparam int NPE = NUM_PE_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sw_array_ctrl_if bus ();

  sw_array_ctrl #(.NUM_PE(NPE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Read in alignment order (fed last base first) and reference in order.
  base_e rd_seq  [NPE] = '{BASE_A, BASE_C, BASE_A, BASE_T, BASE_T, BASE_A, BASE_C, BASE_G};
  base_e ref_seq [NPE] = '{BASE_A, BASE_C, BASE_A, BASE_G, BASE_A, BASE_C, BASE_T, BASE_A};
  logic [SCORE_W-1:0] cummax [NPE];

  // Linear-gap local alignment: match +2, mismatch -1, gap -1.
  // cummax[j] is the best cell over reference columns 0..j.
  function automatic void sw_model();
    int h [0:NPE][0:NPE];
    int best = 0;
    for (int i = 0; i <= NPE; i++)
      for (int j = 0; j <= NPE; j++) h[i][j] = 0;
    for (int j = 1; j <= NPE; j++) begin
      for (int i = 1; i <= NPE; i++) begin
        int s = (rd_seq[i-1] == ref_seq[j-1]) ? 2 : -1;
        int v = 0;
        if (h[i-1][j-1] + s > v) v = h[i-1][j-1] + s;
        if (h[i-1][j] - 1 > v)   v = h[i-1][j] - 1;
        if (h[i][j-1] - 1 > v)   v = h[i][j-1] - 1;
        h[i][j] = v;
        if (v > best) best = v;
      end
      cummax[j-1] = SCORE_W'(best);
    end
  endfunction

  typedef struct {
    string name;
    int    ref_len;
    bit    rd_gap;      // rd_valid toggles 1/0 from the first LOAD cycle
    int    abort_after; // ref_valid drops after this many accepted bases
    bit    use_model;   // tail values from the SW model, else 5,9,9,3
    int    exp_max;     // used only when use_model is 0
    int    exp_done;    // done cycle, start asserted in cycle 0
    bit    exp_err;
    int    exp_store;
    int    exp_init;
    int    exp_rd_hs;
    int    exp_ref_hs;
    bit    poke_start;  // extra start pulses while busy and in the DONE cycle
  } vec_t;

  vec_t vecs [5];

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.ref_len   = '0;
    bus.rd_valid  = 1'b0;
    bus.rd_base   = '0;
    bus.ref_valid = 1'b0;
    bus.ref_base  = '0;
    bus.tail_V    = '0;
    bus.tail_init = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"},       bus.busy,       0);
    check({tag, " done"},       bus.done,       0);
    check({tag, " err"},        bus.err,        0);
    check({tag, " max_score"},  bus.max_score,  0);
    check({tag, " rd_ready"},   bus.rd_ready,   0);
    check({tag, " ref_ready"},  bus.ref_ready,  0);
    check({tag, " pe_store_S"}, bus.pe_store_S, 0);
    check({tag, " pe_init"},    bus.pe_init,    0);
    check({tag, " pe_S"},       bus.pe_S,       0);
    check({tag, " pe_T"},       bus.pe_T,       0);
    check({tag, " pe_V"},       bus.pe_V,       0);
    check({tag, " pe_F"},       bus.pe_F,       0);
  endtask

  // Runs one job starting at posedge+1 in IDLE. rst_at >= 0 pulls reset
  // asynchronously in that cycle, checks reset values, and returns.
  task automatic run_job(input vec_t v, input int rst_at);
    int c = 0, done_c = -1;
    int store_cnt = 0, init_cnt = 0, init_runs = 0;
    int rd_hs = 0, ref_hs = 0, rd_sent = 0, ref_sent = 0;
    bit prev_init = 0, order_ok = 1, restarted = 0;
    logic busy_c1 = 1'b0, busy_at_done = 1'b1, err_at_done = 1'b0;
    logic [SCORE_W-1:0] max_at_done = '0;
    logic [SCORE_W-1:0] tv [16];
    logic [SCORE_W-1:0] exp_max;
    bit sh_v [NPE+1];
    int sh_c [NPE+1];

    for (int k = 0; k < 16; k++) tv[k] = '0;
    if (v.use_model) begin
      for (int k = 0; k < NPE; k++) tv[k] = cummax[k];
      exp_max = (v.exp_init > 0) ? cummax[v.exp_init-1] : '0;
    end else begin
      tv[0] = 5; tv[1] = 9; tv[2] = 9; tv[3] = 3;
      exp_max = SCORE_W'(v.exp_max);
    end
    for (int k = 0; k <= NPE; k++) begin sh_v[k] = 0; sh_c[k] = 0; end

    while (c < 300) begin
      // Observe cycle c.
      if (bus.pe_store_S) begin
        if (bus.pe_S !== rd_seq[NPE-1-(store_cnt % NPE)]) order_ok = 0;
        store_cnt++;
      end
      if (bus.pe_init) begin
        if (!prev_init) init_runs++;
        init_cnt++;
      end
      prev_init = bus.pe_init;
      if (c == 1) busy_c1 = bus.busy;
      if (bus.done && done_c < 0) begin
        done_c       = c;
        busy_at_done = bus.busy;
        err_at_done  = bus.err;
        max_at_done  = bus.max_score;
      end
      if (done_c >= 0 && c > done_c && bus.busy) restarted = 1;

      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1 check_reset_values("async_reset");
        idle_inputs();
        return;
      end
      if (done_c >= 0 && c >= done_c + 3) break;

      // Chain model: tail sees pe_init NPE cycles late; garbage when idle.
      for (int k = NPE; k > 0; k--) begin sh_v[k] = sh_v[k-1]; sh_c[k] = sh_c[k-1]; end
      sh_v[0] = bus.pe_init;
      sh_c[0] = init_cnt - 1;
      bus.tail_init = sh_v[NPE];
      if (sh_v[NPE]) bus.tail_V = tv[sh_c[NPE] % 16];
      else           bus.tail_V = '1;

      // Drive cycle c.
      bus.start     = (c == 0) || (v.poke_start && (c == 5 || c == v.exp_done));
      bus.ref_len   = (c == 0) ? REF_LEN_W'(v.ref_len) : REF_LEN_W'(3);
      bus.rd_valid  = v.rd_gap ? (c % 2 == 1) : 1'b1;
      bus.rd_base   = rd_seq[NPE-1-(rd_sent % NPE)];
      bus.ref_valid = (ref_sent < v.abort_after);
      bus.ref_base  = ref_seq[ref_sent % NPE];
      if (bus.rd_valid && bus.rd_ready)   begin rd_sent++;  rd_hs++;  end
      if (bus.ref_valid && bus.ref_ready) begin ref_sent++; ref_hs++; end

      @(posedge clk);
      #1;
      c++;
    end
    idle_inputs();

    check({v.name, " done_cycle"}, done_c, v.exp_done);
    check({v.name, " busy_after_start"}, busy_c1, (v.exp_done >= 2));
    check({v.name, " busy_in_done"}, busy_at_done, 0);
    check({v.name, " err"}, err_at_done, v.exp_err);
    check({v.name, " max_score"}, max_at_done, exp_max);
    check({v.name, " store_S_pulses"}, store_cnt, v.exp_store);
    check({v.name, " store_S_order"}, order_ok, 1);
    check({v.name, " init_pulses"}, init_cnt, v.exp_init);
    check({v.name, " init_runs"}, init_runs, (v.exp_init > 0) ? 1 : 0);
    check({v.name, " rd_handshakes"}, rd_hs, v.exp_rd_hs);
    check({v.name, " ref_handshakes"}, ref_hs, v.exp_ref_hs);
    check({v.name, " no_restart"}, restarted, 0);
  endtask

  initial begin
    idle_inputs();
    sw_model();

    //          name     len gap abort model max done err store init rd ref poke
    vecs[0] = '{"full",   8, 0,  99,   1,    0,  26, 0,  8,    8,   8, 8,  0};
    vecs[1] = '{"gap",    8, 1,  99,   1,    0,  33, 0,  8,    8,   8, 8,  0};
    vecs[2] = '{"abort",  8, 0,  3,    1,    0,  22, 1,  8,    3,   8, 3,  0};
    vecs[3] = '{"zero",   0, 0,  99,   1,    0,  2,  0,  0,    0,   0, 0,  0};
    vecs[4] = '{"ignore", 4, 0,  99,   0,    9,  22, 0,  8,    4,   8, 4,  1};

    #12 check_reset_values("por");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i], -1);
      @(posedge clk); #1;
    end

    // Reset during STREAM, then a full job must still produce the full result.
    run_job(vecs[0], 11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vecs[0].name = "after_reset";
    run_job(vecs[0], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
